// File: rtl/demux_route_pkg.sv
// ============================================================================
// Module      : demux_route_pkg
// Description : Shared types and constants for the demux route controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package demux_route_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUTE0 = 2'd1,
        ROUTE1 = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    localparam logic DEST0 = 1'b0;
    localparam logic DEST1 = 1'b1;

    function automatic logic is_route(input state_e s);
        return (s == ROUTE0) || (s == ROUTE1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/demux_route_ctrl_if.sv
// ============================================================================
// Module      : demux_route_ctrl_if
// Description : Input stream plus two destination streams (valid/ready).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface demux_route_ctrl_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out0_data;
    logic                  out0_valid;
    logic                  out0_ready;
    logic [DATA_WIDTH-1:0] out1_data;
    logic                  out1_valid;
    logic                  out1_ready;

    // master = the routing controller, slave = source and destinations
    modport master (
        input  in_data, in_valid, out0_ready, out1_ready,
        output in_ready, out0_data, out0_valid, out1_data, out1_valid
    );

    modport slave (
        output in_data, in_valid, out0_ready, out1_ready,
        input  in_ready, out0_data, out0_valid, out1_data, out1_valid
    );
endinterface

`default_nettype wire

// File: rtl/demux_route_ctrl_demux.sv
// ============================================================================
// Module      : demux_route_ctrl_demux
// Description : 1:2 data demux; the unselected (or idle) output reads zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_route_ctrl_demux
    import demux_route_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  wire logic                  i_en,
    input  wire logic                  i_sel,
    input  wire logic [DATA_WIDTH-1:0] i_data,
    output logic      [DATA_WIDTH-1:0] o_data0,
    output logic      [DATA_WIDTH-1:0] o_data1
);
    assign o_data0 = (i_en && (i_sel == DEST0)) ? i_data : '0;
    assign o_data1 = (i_en && (i_sel == DEST1)) ? i_data : '0;
endmodule

`default_nettype wire

// File: rtl/demux_route_ctrl.sv
// ============================================================================
// Module      : demux_route_ctrl
// Description : Steers a word stream LEN0 words to dest 0, LEN1 to dest 1,
//               repeated PASSES times, through a one-entry output buffer.
//               Optional stall counter: DEMUX_ROUTE_CTRL_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_route_ctrl
    import demux_route_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 8,
    parameter int PASS_WIDTH = 8
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  start,
    input  wire logic [LEN_WIDTH-1:0]  cfg_len0,
    input  wire logic [LEN_WIDTH-1:0]  cfg_len1,
    input  wire logic [PASS_WIDTH-1:0] cfg_passes,
    demux_route_ctrl_if.master         bus,
    output logic                       busy,
    output logic                       done
`ifdef DEMUX_ROUTE_CTRL_STALL_CNT_EN
    ,
    output logic [31:0]                stall_cnt
`endif
);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [PASS_WIDTH-1:0] PASS_ONE = PASS_WIDTH'(1);

    state_e                  state_q, state_d;
    logic [LEN_WIDTH-1:0]    len0_q, len0_d, len1_q, len1_d;
    logic [LEN_WIDTH-1:0]    word_cnt_q, word_cnt_d;
    logic [PASS_WIDTH-1:0]   passes_q, passes_d, pass_cnt_q, pass_cnt_d;
    logic [DATA_WIDTH-1:0]   buf_data_q, buf_data_d;
    logic                    buf_dest_q, buf_dest_d;
    logic                    buf_valid_q, buf_valid_d;

    logic                    w_fire, w_in_ready, w_accept, w_pass_end;
    logic [LEN_WIDTH-1:0]    w_word_inc;
    logic [PASS_WIDTH-1:0]   w_pass_inc;

    assign w_fire     = buf_valid_q & ((buf_dest_q == DEST1) ? bus.out1_ready : bus.out0_ready);
    assign w_in_ready = is_route(state_q) & (~buf_valid_q | w_fire);
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_word_inc = word_cnt_q + LEN_ONE;
    assign w_pass_inc = pass_cnt_q + PASS_ONE;

    assign bus.in_ready   = w_in_ready;
    assign bus.out0_valid = buf_valid_q & (buf_dest_q == DEST0);
    assign bus.out1_valid = buf_valid_q & (buf_dest_q == DEST1);
    assign busy           = (state_q != IDLE);

    demux_route_ctrl_demux #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_demux (
        .i_en    (buf_valid_q),
        .i_sel   (buf_dest_q),
        .i_data  (buf_data_q),
        .o_data0 (bus.out0_data),
        .o_data1 (bus.out1_data)
    );

    always_comb begin
        state_d    = state_q;
        len0_d     = len0_q;
        len1_d     = len1_q;
        passes_d   = passes_q;
        word_cnt_d = word_cnt_q;
        pass_cnt_d = pass_cnt_q;
        w_pass_end = 1'b0;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    len0_d     = cfg_len0;
                    len1_d     = cfg_len1;
                    passes_d   = cfg_passes;
                    word_cnt_d = '0;
                    pass_cnt_d = '0;
                    if (cfg_passes == '0)     state_d = DRAIN;
                    else if (cfg_len0 != '0)  state_d = ROUTE0;
                    else if (cfg_len1 != '0)  state_d = ROUTE1;
                    else                      state_d = DRAIN;
                end
            end
            ROUTE0: begin
                if (w_accept) begin
                    if (w_word_inc == len0_q) begin
                        word_cnt_d = '0;
                        if (len1_q != '0) state_d = ROUTE1;
                        else              w_pass_end = 1'b1;
                    end else begin
                        word_cnt_d = w_word_inc;
                    end
                end
            end
            ROUTE1: begin
                if (w_accept) begin
                    if (w_word_inc == len1_q) begin
                        word_cnt_d = '0;
                        w_pass_end = 1'b1;
                    end else begin
                        word_cnt_d = w_word_inc;
                    end
                end
            end
            DRAIN: begin
                // the last word may still be leaving the buffer this cycle
                if (~buf_valid_q | w_fire) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (w_pass_end) begin
            pass_cnt_d = w_pass_inc;
            if (w_pass_inc == passes_q) state_d = DRAIN;
            else if (len0_q != '0)      state_d = ROUTE0;
            else                        state_d = ROUTE1;
        end
    end

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        buf_dest_d  = buf_dest_q;
        if (w_accept) begin
            buf_valid_d = 1'b1;
            buf_data_d  = bus.in_data;
            buf_dest_d  = (state_q == ROUTE1) ? DEST1 : DEST0;
        end else if (w_fire) begin
            buf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            len0_q      <= '0;
            len1_q      <= '0;
            passes_q    <= '0;
            word_cnt_q  <= '0;
            pass_cnt_q  <= '0;
            buf_data_q  <= '0;
            buf_dest_q  <= DEST0;
            buf_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len0_q      <= len0_d;
            len1_q      <= len1_d;
            passes_q    <= passes_d;
            word_cnt_q  <= word_cnt_d;
            pass_cnt_q  <= pass_cnt_d;
            buf_data_q  <= buf_data_d;
            buf_dest_q  <= buf_dest_d;
            buf_valid_q <= buf_valid_d;
        end
    end

`ifdef DEMUX_ROUTE_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == IDLE) && start)
            stall_cnt_d = '0;
        else if (buf_valid_q && !w_fire && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux_route_ctrl.sv
// ============================================================================
// Module      : tb_demux_route_ctrl
// Description : Self-checking bench; expected routing derived from the
//               configured pattern (dest sequence list + one-slot pending word).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux_route_ctrl;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [7:0]  cfg_len0, cfg_len1, cfg_passes;
    logic        busy, done;
`ifdef DEMUX_ROUTE_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    demux_route_ctrl_if #(.DATA_WIDTH(16)) bus ();

    demux_route_ctrl #(
        .DATA_WIDTH (16),
        .LEN_WIDTH  (8),
        .PASS_WIDTH (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cfg_len0   (cfg_len0),
        .cfg_len1   (cfg_len1),
        .cfg_passes (cfg_passes),
        .bus        (bus),
        .busy       (busy),
        .done       (done)
`ifdef DEMUX_ROUTE_CTRL_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // stimulus requested for the next cycle
    logic        d_reset = 1'b1, d_start = 1'b0, d_valid = 1'b0, d_r0 = 1'b1, d_r1 = 1'b1;
    logic [7:0]  d_len0 = 8'd0, d_len1 = 8'd0, d_passes = 8'd0;

    int checks = 0, errors = 0;

    // reference model: ordered destination list for the running transfer
    bit          seq[$];
    int          acc = 0;
    bit          m_active = 0, pend_valid = 0, pend_dest = 0;
    logic [15:0] pend_data = '0;
    longint      m_stall = 0;

    int n_busy, n_done, n_o0, n_o1, n_v0, n_v1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        n_busy = 0; n_done = 0; n_o0 = 0; n_o1 = 0; n_v0 = 0; n_v1 = 0;
    endtask

    task automatic cycle();
        logic [15:0] dat;
        bit fire, e_in_ready, e_done;
        @(posedge clk); #1;
        dat            = 16'($urandom);
        reset          = d_reset;
        start          = d_start;
        cfg_len0       = d_len0;
        cfg_len1       = d_len1;
        cfg_passes     = d_passes;
        bus.in_valid   = d_valid;
        bus.in_data    = dat;
        bus.out0_ready = d_r0;
        bus.out1_ready = d_r1;
        #1;
        fire       = pend_valid && (pend_dest ? d_r1 : d_r0);
        e_in_ready = m_active && (acc < seq.size()) && (!pend_valid || fire);
        e_done     = m_active && (acc == seq.size()) && (!pend_valid || fire);

        chk("in_ready",   32'(bus.in_ready),   32'(e_in_ready));
        chk("out0_valid", 32'(bus.out0_valid), 32'(pend_valid && !pend_dest));
        chk("out1_valid", 32'(bus.out1_valid), 32'(pend_valid && pend_dest));
        chk("out0_data",  32'(bus.out0_data),  (pend_valid && !pend_dest) ? 32'(pend_data) : 32'd0);
        chk("out1_data",  32'(bus.out1_data),  (pend_valid && pend_dest) ? 32'(pend_data) : 32'd0);
        chk("busy",       32'(busy),           32'(m_active));
        chk("done",       32'(done),           32'(e_done));
`ifdef DEMUX_ROUTE_CTRL_STALL_CNT_EN
        chk("stall_cnt",  stall_cnt,           32'(m_stall));
`endif
        if (busy) n_busy++;
        if (done) n_done++;
        if (bus.out0_valid) n_v0++;
        if (bus.out1_valid) n_v1++;
        if (bus.out0_valid && d_r0) n_o0++;
        if (bus.out1_valid && d_r1) n_o1++;

        if (d_reset) begin
            seq.delete(); acc = 0; m_active = 0; pend_valid = 0; pend_dest = 0;
            pend_data = '0; m_stall = 0;
        end else begin
            if (pend_valid && !fire && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (d_valid && e_in_ready) begin
                pend_valid = 1; pend_dest = seq[acc]; pend_data = dat; acc++;
            end else if (fire) begin
                pend_valid = 0;
            end
            if (e_done) begin
                m_active = 0;
            end else if (!m_active && d_start) begin
                seq.delete();
                for (int p = 0; p < int'(d_passes); p++) begin
                    for (int i = 0; i < int'(d_len0); i++) seq.push_back(1'b0);
                    for (int i = 0; i < int'(d_len1); i++) seq.push_back(1'b1);
                end
                acc = 0; m_active = 1; m_stall = 0;
            end
        end
    endtask

    task automatic pulse_start(input int l0, input int l1, input int ps);
        d_len0 = 8'(l0); d_len1 = 8'(l1); d_passes = 8'(ps);
        d_start = 1; cycle(); d_start = 0;
    endtask

    task automatic run_to_idle(input int budget, input bit rnd);
        int n = 0;
        while (m_active && n < budget) begin
            if (rnd) begin
                d_valid = ($urandom_range(0, 9) < 7);
                d_r0    = ($urandom_range(0, 9) < 6);
                d_r1    = ($urandom_range(0, 9) < 6);
                d_start = ($urandom_range(0, 15) == 0);
                d_len0  = 8'($urandom); d_len1 = 8'($urandom); d_passes = 8'($urandom);
            end
            cycle();
            n++;
        end
        d_start = 0;
        chk("idle_within_budget", 32'(n < budget), 32'd1);
    endtask

    initial begin
        reset = 1; start = 0; cfg_len0 = 0; cfg_len1 = 0; cfg_passes = 0;
        bus.in_valid = 0; bus.in_data = '0; bus.out0_ready = 1; bus.out1_ready = 1;

        // reset state
        repeat (3) cycle();
        d_reset = 0;
        cycle();

        // basic pattern 3/2/2 at full throughput
        clr_stats(); d_valid = 1; d_r0 = 1; d_r1 = 1;
        pulse_start(3, 2, 2);
        run_to_idle(60, 0);
        chk("basic_busy_cycles", n_busy, 11);
        chk("basic_done", n_done, 1);
        chk("basic_out0", n_o0, 6);
        chk("basic_out1", n_o1, 4);

        // zero-length first phase
        clr_stats();
        pulse_start(0, 4, 1);
        run_to_idle(40, 0);
        chk("zero_v0", n_v0, 0);
        chk("zero_out1", n_o1, 4);
        chk("zero_done", n_done, 1);

        // backpressure on dest 0 for 5 cycles after first word
        clr_stats();
        pulse_start(2, 2, 1);
        cycle();
        d_r0 = 0;
        repeat (5) cycle();
        d_r0 = 1;
        run_to_idle(40, 0);
        chk("bp_out0", n_o0, 2);
        chk("bp_out1", n_o1, 2);
`ifdef DEMUX_ROUTE_CTRL_STALL_CNT_EN
        chk("bp_stall_cnt", stall_cnt, 5);
`endif

        // empty transfer
        clr_stats();
        pulse_start(3, 3, 0);
        cycle();
        chk("empty_done_next", n_done, 1);
        run_to_idle(10, 0);
        chk("empty_no_valid", n_v0 + n_v1, 0);

        // start while busy is ignored
        clr_stats();
        pulse_start(3, 2, 2);
        repeat (4) cycle();
        pulse_start(1, 1, 5);
        run_to_idle(60, 0);
        chk("busy_start_out0", n_o0, 6);
        chk("busy_start_out1", n_o1, 4);
        chk("busy_start_done", n_done, 1);

        // reset after 3 of 6 words
        pulse_start(3, 3, 1);
        repeat (3) cycle();
        d_reset = 1; d_valid = 0;
        cycle();
        d_reset = 0;
        cycle();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out0_valid", 32'(bus.out0_valid), 0);
        chk("rst_out0_data", 32'(bus.out0_data), 0);
        clr_stats(); d_valid = 1;
        pulse_start(2, 1, 1);
        run_to_idle(40, 0);
        chk("post_rst_out0", n_o0, 2);
        chk("post_rst_out1", n_o1, 1);
        chk("post_rst_done", n_done, 1);

        // randomized traffic, config and stray starts
        for (int t = 0; t < 30; t++) begin
            int l0, l1, ps;
            l0 = $urandom_range(0, 4); l1 = $urandom_range(0, 4); ps = $urandom_range(0, 3);
            clr_stats();
            pulse_start(l0, l1, ps);
            run_to_idle(400, 1);
            chk("rnd_out0", n_o0, l0 * ps);
            chk("rnd_out1", n_o1, l1 * ps);
            chk("rnd_done", n_done, 1);
        end

        d_valid = 0;
        repeat (2) cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
